// File: rtl/text_write_master.sv
// Host-side bus initiator: turns a (char, linear position) request into the
// video card's write-character register sequence CMD, ARG0, ARG2, ARG3, GAP.
module text_write_master #(
  parameter int         COLS           = 80,
  parameter int         ROWS           = 30,
  parameter int         HOLD_CYCLES    = 1,
  parameter logic [7:0] CMD_WRITE_CHAR = 8'h00
) (
  input  logic        cpu_clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_char,
  input  logic [11:0] req_pos,
  output logic        ce,
  output logic        rw,
  output logic [3:0]  addr,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        busy,
  output logic        err
);

  localparam int              POS_LIMIT   = COLS * ROWS;
  localparam int              HW          = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]   HOLD_RELOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [11:0]     COLS_W      = 12'(COLS);

  typedef enum logic [2:0] {
    S_IDLE, S_DIV, S_CMD, S_ARG0, S_ARG2, S_ARG3, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [7:0]    char_q, char_d;
  logic [11:0]   rem_q, rem_d;
  logic [7:0]    row_q, row_d;
  logic          err_q, err_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          ce_q, ce_d;
  logic          rw_q, rw_d;
  logic [3:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          oe_q, oe_d;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    char_d  = char_q;
    rem_d   = rem_q;
    row_d   = row_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (32'(req_pos) < POS_LIMIT) begin
            char_d  = req_char;
            rem_d   = req_pos;
            row_d   = 8'd0;
            state_d = S_DIV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      // rem ends up holding the column once it drops below COLS
      S_DIV: begin
        if (rem_q >= COLS_W) begin
          rem_d = rem_q - COLS_W;
          row_d = row_q + 8'd1;
        end else begin
          state_d = S_CMD;
          hold_d  = HOLD_RELOAD;
        end
      end
      S_CMD, S_ARG0, S_ARG2, S_ARG3, S_GAP: begin
        if (hold_q == '0) begin
          hold_d = HOLD_RELOAD;
          case (state_q)
            S_CMD:   state_d = S_ARG0;
            S_ARG0:  state_d = S_ARG2;
            S_ARG2:  state_d = S_ARG3;
            S_ARG3:  state_d = S_GAP;
            default: state_d = S_IDLE;
          endcase
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies
    // track the state register exactly.
    ready_d = (state_d == S_IDLE);
    busy_d  = !ready_d;
    ce_d    = 1'b0;
    rw_d    = 1'b0;
    addr_d  = 4'd0;
    data_d  = 8'd0;
    case (state_d)
      S_CMD:  begin ce_d = 1'b1; rw_d = 1'b1; addr_d = 4'd0; data_d = CMD_WRITE_CHAR; end
      S_ARG0: begin ce_d = 1'b1; rw_d = 1'b1; addr_d = 4'd1; data_d = char_d;         end
      S_ARG2: begin ce_d = 1'b1; rw_d = 1'b1; addr_d = 4'd3; data_d = row_d;          end
      S_ARG3: begin ce_d = 1'b1; rw_d = 1'b1; addr_d = 4'd4; data_d = rem_d[7:0];     end
      default: ;
    endcase
    oe_d = ce_d & rw_d;
  end

  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      char_q  <= 8'd0;
      rem_q   <= 12'd0;
      row_q   <= 8'd0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      ce_q    <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= 4'd0;
      data_q  <= 8'd0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      char_q  <= char_d;
      rem_q   <= rem_d;
      row_q   <= row_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      ce_q    <= ce_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      oe_q    <= oe_d;
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign ce        = ce_q;
  assign rw        = rw_q;
  assign addr      = addr_q;
  assign data_out  = data_q;
  assign data_oe   = oe_q;

endmodule
